x25519_mult_core: RTL and testbench

// - GF(2^255-19) multiplier datapath for the X25519 ladder: a*b mod p in radix-2^8, 32 limbs.
// - Unpacks both operands, builds the 32 product limbs one at a time, then carry-reduces them.
// - Output is bit-exact with the NaCl ref mult(); it is partially reduced, not canonical.
// - Sits between the ladder sequencer and the register file. One multiply in flight.

---
 rtl/x25519_mult_core.sv | 136 +++++++++++++
 tb/tb_x25519_mult_core.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/x25519_mult_core.sv
// x25519_mult_core
//   GF(2^255-19) multiplier for the X25519 ladder. Radix 2^8, 32 limbs. The result
//   matches NaCl mult() bit for bit. It is partially reduced, not canonical.
//   One multiply-accumulate per cycle. Each of the 32 product limbs t[i] is a
//   32-term pass. The first carry sweep consumes each t[i] as its pass completes,
//   and a second 32-step carry sweep follows.
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset (wins over en)
//   en         start pulse; a/b captured this cycle, any op in flight is dropped
//   a, b       operands: limb j in [8j+7:8j] for j=0..30, limb 31 in [263:248]
//   out_valid  one-cycle pulse while in DONE
//   out        product, same packing; held until the next DONE or reset
// Latency
//   en is sampled at edge E. The passes run on edges E+1..E+1024 and the second
//   sweep on E+1025..E+1056. out_valid is high in the cycle after edge E+1056,
//   so L = 1056 cycles regardless of operand values.
module x25519_mult_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [263:0] a,
    input  logic [263:0] b,
    output logic         out_valid,
    output logic [263:0] out
);
    localparam int ACC_W = 44;  // 32 * 38 * (2^16-1)^2 < 2^43
    localparam int U_W   = 48;

    typedef enum logic [1:0] {IDLE, PASS, SQZ2, DONE} state_t;
    state_t state, state_nxt;

    logic [15:0]      a_limb [32];
    logic [15:0]      b_rot  [32];  // pass i, slot j holds b[(i-j) mod 32]
    logic [15:0]      r      [32];  // limbs 0..30 use 8 bits, limb 31 up to 16
    logic [ACC_W-1:0] acc;
    logic [U_W-1:0]   u;
    logic [4:0]       pass_i;
    logic [4:0]       term_j;

    logic [31:0]      prod;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] t_done;
    logic [U_W-1:0]   u_sum1;
    logic [U_W-1:0]   u_sum2;
    logic [15:0]      top_fin;

    assign prod    = {16'd0, a_limb[term_j]} * {16'd0, b_rot[term_j]};
    // Terms with j > i wrap past limb 31. 2^256 = 38 mod p, so these terms are scaled by 38.
    assign term    = (term_j > pass_i) ? {12'd0, prod} * 44'd38 : {12'd0, prod};
    assign t_done  = acc + term;
    assign u_sum1  = u + {4'd0, t_done};
    assign u_sum2  = u + {32'd0, r[term_j]};
    assign top_fin = r[31] + u[15:0];

    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            PASS:    if (term_j == 5'd31 && pass_i == 5'd31) state_nxt = SQZ2;
            SQZ2:    if (term_j == 5'd31) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (en) state_nxt = PASS;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            u      <= '0;
            pass_i <= '0;
            term_j <= '0;
            out    <= '0;
            for (int k = 0; k < 32; k++) begin
                a_limb[k] <= '0;
                b_rot[k]  <= '0;
                r[k]      <= '0;
            end
        end else if (en) begin
            acc    <= '0;
            u      <= '0;
            pass_i <= '0;
            term_j <= '0;
            for (int k = 0; k < 31; k++) a_limb[k] <= {8'd0, a[8*k +: 8]};
            a_limb[31] <= a[263:248];
            // Load B mirrored so that pass 0 slot j holds b[(-j) mod 32].
            b_rot[0] <= {8'd0, b[7:0]};
            b_rot[1] <= b[263:248];
            for (int k = 2; k < 32; k++) b_rot[k] <= {8'd0, b[8*(32-k) +: 8]};
            for (int k = 0; k < 32; k++) r[k] <= '0;
        end else begin
            case (state)
                PASS: begin
                    term_j <= term_j + 5'd1;
                    if (term_j == 5'd31) begin
                        // t[pass_i] is complete. Run one step of the first carry sweep on it now.
                        acc    <= '0;
                        pass_i <= pass_i + 5'd1;
                        b_rot[0] <= b_rot[31];
                        for (int k = 1; k < 32; k++) b_rot[k] <= b_rot[k-1];
                        if (pass_i == 5'd31) begin
                            r[31] <= {9'd0, u_sum1[6:0]};
                            // Fold bits at 2^255 and above back into the low limbs (2^255 = 19 mod p).
                            u <= (u_sum1 >> 7) * 48'd19;
                        end else begin
                            r[pass_i] <= {8'd0, u_sum1[7:0]};
                            u <= u_sum1 >> 8;
                        end
                    end else begin
                        acc <= t_done;
                    end
                end
                SQZ2: begin
                    term_j <= term_j + 5'd1;
                    if (term_j == 5'd31) begin
                        r[31] <= top_fin;
                        for (int k = 0; k < 31; k++) out[8*k +: 8] <= r[k][7:0];
                        out[263:248] <= top_fin;
                    end else begin
                        r[term_j] <= {8'd0, u_sum2[7:0]};
                        u <= u_sum2 >> 8;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_x25519_mult_core.sv
// tb_x25519_mult_core
//   Self-checking bench. Expected products come from a direct transcription of the
//   NaCl mult()/squeeze() C code. They are pushed to a scoreboard when en is driven.
//   A negedge monitor pops one entry on every out_valid pulse and checks the value
//   and the fixed latency.
module tb_x25519_mult_core;
    localparam int L = 1056;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [263:0] a = '0;
    logic [263:0] b = '0;
    logic         out_valid;
    logic [263:0] out;

    always #5 clk = ~clk;

    x25519_mult_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out       (out)
    );

    typedef struct {
        logic [263:0] exp;
        int           start;
    } sb_t;

    typedef struct {
        string        name;
        logic [263:0] a;
        logic [263:0] b;
        logic [263:0] exp;
    } vec_t;

    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // NaCl mult() followed by squeeze(), with 32-bit unsigned wrap as in C.
    function automatic logic [263:0] ref_mult(input logic [263:0] x, input logic [263:0] y);
        longint unsigned xa[32];
        longint unsigned yb[32];
        longint unsigned t[32];
        longint unsigned u;
        longint unsigned m;
        logic [263:0]    res;
        m = 64'hFFFF_FFFF;
        for (int j = 0; j < 31; j++) begin
            xa[j] = {56'd0, x[8*j +: 8]};
            yb[j] = {56'd0, y[8*j +: 8]};
        end
        xa[31] = {48'd0, x[263:248]};
        yb[31] = {48'd0, y[263:248]};
        for (int i = 0; i < 32; i++) begin
            u = 0;
            for (int j = 0; j <= i; j++) u = (u + ((xa[j] * yb[i-j]) & m)) & m;
            for (int j = i + 1; j < 32; j++) u = (u + ((38 * xa[j] * yb[i+32-j]) & m)) & m;
            t[i] = u;
        end
        u = 0;
        for (int j = 0; j < 31; j++) begin
            u = (u + t[j]) & m; t[j] = u & 255; u = u >> 8;
        end
        u = (u + t[31]) & m; t[31] = u & 127;
        u = (19 * (u >> 7)) & m;
        for (int j = 0; j < 31; j++) begin
            u = (u + t[j]) & m; t[j] = u & 255; u = u >> 8;
        end
        u = (u + t[31]) & m; t[31] = u;
        for (int j = 0; j < 31; j++) res[8*j +: 8] = t[j][7:0];
        res[263:248] = t[31][15:0];
        return res;
    endfunction

    function automatic logic [263:0] rand_op();
        logic [263:0] v;
        for (int j = 0; j < 31; j++) v[8*j +: 8] = 8'($urandom_range(0, 255));
        v[263:248] = 16'($urandom_range(0, 511));
        return v;
    endfunction

    // Monitor: every out_valid must match the oldest pending op, arrive after exactly L cycles, and last one cycle.
    always @(negedge clk) begin : mon
        sb_t e;
        if (out_valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_valid: out_valid=1 with no op pending, out=%h cycle=%0d", out, cyc);
            end else begin
                e = sb.pop_front();
                checks++;
                if (out !== e.exp) begin
                    errors++;
                    $display("FAIL product: got %h want %h", out, e.exp);
                end
                checks++;
                if (cyc - e.start != L) begin
                    errors++;
                    $display("FAIL latency: got %0d want %0d", cyc - e.start, L);
                end
            end
        end
        if (prev_valid) begin
            checks++;
            if (out_valid) begin
                errors++;
                $display("FAIL pulse_width: out_valid high for two consecutive cycles at cycle %0d", cyc);
            end
        end
        prev_valid = out_valid;
    end

    // Called on a negedge. The posedge that follows samples en.
    task automatic start_op(input logic [263:0] av, input logic [263:0] bv, input bit abort_prev);
        sb_t e;
        if (abort_prev) sb.delete();
        a = av; b = bv; en = 1'b1;
        e.exp = ref_mult(av, bv);
        e.start = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic end_en();
        en = 1'b0;
        a = rand_op();
        b = rand_op();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (sb.size() != 0 && k < L + 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d op(s) still pending after %0d cycles", sb.size(), k);
            sb.delete();
        end
    endtask

    initial begin
        vec_t         tbl[$];
        vec_t         tv;
        logic [263:0] x;
        logic [263:0] y;
        logic [263:0] held;
        int           k;

        tv.name = "one_x_one";   tv.a = 264'h1;          tv.b = 264'h1;          tv.exp = 264'h1;      tbl.push_back(tv);
        tv.name = "ff_x_ff";     tv.a = 264'hFF;         tv.b = 264'hFF;         tv.exp = 264'hFE01;   tbl.push_back(tv);
        tv.name = "wrap_38";     tv.a = 264'h100;        tv.b = 264'h1 << 248;   tv.exp = 264'd38;     tbl.push_back(tv);
        tv.name = "wrap_19";     tv.a = 264'h80 << 248;  tv.b = 264'h1;          tv.exp = 264'd19;     tbl.push_back(tv);
        x = {16'h01FF, {31{8'hFF}}};
        tv.name = "all_max";     tv.a = x;               tv.b = x;               tv.exp = ref_mult(x, x); tbl.push_back(tv);

        // Reset state, with en held high during reset: en must be ignored.
        rst_n = 1'b0; en = 1'b1; a = 264'h5; b = 264'h7;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out !== '0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b out=%h want 0/0", out_valid, out);
        end
        rst_n = 1'b1; en = 1'b0;

        // Directed table
        foreach (tbl[i]) begin
            @(negedge clk);
            start_op(tbl[i].a, tbl[i].b, 1'b0);
            sb[sb.size()-1].exp = tbl[i].exp;
            @(negedge clk);
            end_en();
            wait_idle();
            repeat (3) @(negedge clk);
            checks++;
            if (out !== tbl[i].exp) begin
                errors++;
                $display("FAIL hold_%s: got %h want %h", tbl[i].name, out, tbl[i].exp);
            end
        end

        // Random operands
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            start_op(rand_op(), rand_op(), 1'b0);
            @(negedge clk);
            end_en();
            wait_idle();
        end

        // Back-to-back: each new en lands in the DONE cycle of the previous op
        @(negedge clk);
        start_op(rand_op(), rand_op(), 1'b0);
        @(negedge clk);
        end_en();
        for (int n = 0; n < 3; n++) begin
            k = 0;
            while (!out_valid && k < L + 200) begin
                @(negedge clk);
                k++;
            end
            start_op(rand_op(), rand_op(), 1'b0);
            @(negedge clk);
            end_en();
        end
        wait_idle();

        // en re-asserted during the passes, then on the last cycle of the second sweep
        @(negedge clk);
        start_op(rand_op(), rand_op(), 1'b0);
        @(negedge clk);
        end_en();
        repeat (300) @(negedge clk);
        start_op(rand_op(), rand_op(), 1'b1);
        @(negedge clk);
        end_en();
        repeat (1055) @(negedge clk);
        start_op(rand_op(), rand_op(), 1'b1);
        @(negedge clk);
        end_en();
        wait_idle();

        // Reset mid-op with en high: nothing may come out, out clears, then a fresh op works
        held = out;
        @(negedge clk);
        start_op(rand_op(), rand_op(), 1'b0);
        @(negedge clk);
        end_en();
        repeat (500) @(negedge clk);
        rst_n = 1'b0; en = 1'b1; a = rand_op(); b = rand_op();
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out !== '0) begin
            errors++;
            $display("FAIL reset_midop: out_valid=%b out=%h want 0/0 (prior out %h)", out_valid, out, held);
        end
        repeat (L + 50) @(negedge clk);
        @(negedge clk);
        start_op(rand_op(), rand_op(), 1'b0);
        @(negedge clk);
        end_en();
        wait_idle();

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
